multi_stream_pf_ctrl: RTL and testbench
=======================================

MULTI_STREAM_PF_CTRL -- requirements
Module: multi_stream_pf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 64, address width.
REQ-002 SHALL have parameter NUM_STREAMS, default 4, number of independent stride contexts; range 2..8.
REQ-003 SHALL have parameters BURST_LEN_WIDTH=8, TID_WIDTH=8, WIN_BITS=6 and CONF_BITS=2, giving burst length, ID, window/outstanding and confidence counter widths.
REQ-004 SHALL have parameter WATCHDOG_SIZE, default 10, idle-timer width.
REQ-005 clk  input  1  clock.
REQ-006 resetN  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  global enable; when low, all state holds and pf_valid holds its value.
REQ-008 ctrl_flush  input  1  drain all streams.
REQ-009 s_ar_valid, s_ar_ready  input  1 each  observed slave AR handshake.
REQ-010 s_ar_addr / s_ar_len / s_ar_id  input  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  observed request fields.
REQ-011 bar, limit  input  ADDR_BITS each  inclusive prefetch range.
REQ-012 window_size  input  WIN_BITS  max outstanding prefetches per stream.
REQ-013 conf_thresh  input  CONF_BITS  confidence required to activate a stream.
REQ-014 watchdog_cnt  input  WATCHDOG_SIZE  idle-cycle limit.
REQ-015 pf_valid output 1, pf_ready input 1, pf_addr output ADDR_BITS, pf_len output BURST_LEN_WIDTH, pf_id output TID_WIDTH, pf_stream output $clog2(NUM_STREAMS): prefetch issue channel.
REQ-016 pf_done input 1, pf_done_stream input $clog2(NUM_STREAMS): one prefetch retired.
REQ-017 stream_flush output NUM_STREAMS, one-cycle pulse per drained stream; stream_active output NUM_STREAMS, per-stream ACTIVE flag; alloc_fail output 1, one-cycle pulse.

Function
REQ-018 An observed access SHALL occur when s_ar_valid&&s_ar_ready; it is in range when bar<=s_ar_addr<=limit.
REQ-019 Each stream SHALL hold state IDLE/TRAIN/ACTIVE/DRAIN together with tid, len, prev_addr, stride, conf, next_addr, outstanding and idle_timer.
REQ-020 An access SHALL match the non-IDLE stream whose tid equals s_ar_id; at most one stream matches per tid.
REQ-021 An in-range unmatched access SHALL allocate the lowest-index IDLE stream, which goes to TRAIN with tid=s_ar_id, len=s_ar_len, prev_addr=s_ar_addr, stride=0, conf=0.
REQ-022 If no stream is IDLE, alloc_fail SHALL pulse the next cycle and no state SHALL change.
REQ-023 Out-of-range unmatched accesses SHALL be ignored.
REQ-024 On a matched access in TRAIN, the block SHALL compute d=s_ar_addr-prev_addr modulo 2^ADDR_BITS (two's complement, so negative strides are allowed) and set prev_addr=s_ar_addr.
REQ-025 In TRAIN, if d==stride and d!=0, conf SHALL increment, saturating; otherwise stride SHALL be set to d and conf cleared.
REQ-026 When the updated conf is >=conf_thresh and stride!=0, the stream SHALL enter ACTIVE with next_addr=s_ar_addr+stride.
REQ-027 In ACTIVE, a matched access with d==stride SHALL only update prev_addr; d==0 SHALL be ignored.
REQ-028 In ACTIVE, any other matched access, or one with s_ar_len!=len, or one out of range, SHALL move the stream to DRAIN.
REQ-029 Issue eligibility SHALL require ACTIVE, outstanding<window_size, bar<=next_addr<=limit and outstanding not at its maximum value.
REQ-030 When pf_valid is low, a round-robin arbiter SHALL pick the eligible stream following the last granted one and register pf_valid=1, pf_addr=next_addr, pf_len, pf_id and pf_stream; issue latency is 1 cycle.
REQ-031 pf_valid and its payload SHALL stay stable until pf_valid&&pf_ready, even if the stream leaves ACTIVE.
REQ-032 On a pf_valid&&pf_ready handshake: next_addr+=stride with wrap, outstanding++, pf_valid=0 the next cycle, and no back-to-back issue.
REQ-033 pf_done SHALL decrement outstanding of pf_done_stream.
REQ-034 Issue and done on the same stream in the same cycle SHALL net to no change; done at outstanding==0 SHALL be ignored.
REQ-035 idle_timer SHALL clear on a matched access or state change and increment otherwise.
REQ-036 At idle_timer==watchdog_cnt, a TRAIN stream SHALL go to IDLE and an ACTIVE stream SHALL go to DRAIN; watchdog_cnt==0 disables the watchdog.
REQ-037 ctrl_flush SHALL move every TRAIN stream to IDLE and every ACTIVE stream to DRAIN in one cycle.
REQ-038 In DRAIN with outstanding==0 and no pending pf_valid for that stream, stream_flush[i] SHALL pulse and the stream SHALL go to IDLE.
REQ-039 If allocation and drain complete in the same cycle, the freed stream SHALL NOT be allocated until the next cycle.

Reset
REQ-040 On resetN low: all streams IDLE, all counters and registers 0, pf_valid=0, stream_flush=0, stream_active=0, alloc_fail=0, arbiter pointer=0.
REQ-041 Reset mid-handshake SHALL drop pf_valid immediately, with no outstanding retained.

Verification
REQ-042 conf_thresh=1, tid 3 accesses 0x1000, 0x1040, 0x1080 -> stream0 ACTIVE after the third access; first pf_addr=0x10C0 with pf_id=3.
REQ-043 window_size=2, pf_ready=1, no pf_done -> exactly 2 issues (0x10C0, 0x1100), then pf_valid stays low; one pf_done -> third issue at 0x1140.
REQ-044 Two ACTIVE streams, both eligible, pf_ready=1 -> grants alternate 0,1,0,1.
REQ-045 Negative stride: 0x2000, 0x1FC0, 0x1F80 with bar=0x1F00 -> issues 0x1F40, then 0x1F00, then stops at the range limit.
REQ-046 ACTIVE stream with 2 outstanding receives ctrl_flush -> DRAIN; stream_flush pulses 1 cycle after the second pf_done.
REQ-047 All NUM_STREAMS streams busy plus a new in-range tid -> alloc_fail pulses once and the contexts are unchanged.

Source files
------------

// File: rtl/multi_stream_pf_ctrl_if.sv
// Bus bundle for the stride prefetcher: observed AR request, prefetch issue and retire.
interface multi_stream_pf_ctrl_if #(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned NUM_STREAMS     = 4,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8
);
  localparam int unsigned SW = $clog2(NUM_STREAMS);

  logic                       s_ar_valid;
  logic                       s_ar_ready;
  logic [ADDR_BITS-1:0]       s_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] s_ar_len;
  logic [TID_WIDTH-1:0]       s_ar_id;
  logic                       pf_valid;
  logic                       pf_ready;
  logic [ADDR_BITS-1:0]       pf_addr;
  logic [BURST_LEN_WIDTH-1:0] pf_len;
  logic [TID_WIDTH-1:0]       pf_id;
  logic [SW-1:0]              pf_stream;
  logic                       pf_done;
  logic [SW-1:0]              pf_done_stream;

  modport master (
    input  s_ar_valid, s_ar_ready, s_ar_addr, s_ar_len, s_ar_id,
    input  pf_ready, pf_done, pf_done_stream,
    output pf_valid, pf_addr, pf_len, pf_id, pf_stream
  );

  modport slave (
    output s_ar_valid, s_ar_ready, s_ar_addr, s_ar_len, s_ar_id,
    output pf_ready, pf_done, pf_done_stream,
    input  pf_valid, pf_addr, pf_len, pf_id, pf_stream
  );
endinterface

// File: rtl/multi_stream_pf_ctrl.sv
// Multi-stream stride prefetcher: learns a per-ID stride from observed AR traffic and
// issues prefetches ahead of each confident stream through a round-robin arbiter.
module multi_stream_pf_ctrl #(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned NUM_STREAMS     = 4,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8,
  parameter int unsigned WIN_BITS        = 6,
  parameter int unsigned CONF_BITS       = 2,
  parameter int unsigned WATCHDOG_SIZE   = 10
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     en,
  input  logic                     ctrl_flush,
  input  logic [ADDR_BITS-1:0]     bar,
  input  logic [ADDR_BITS-1:0]     limit,
  input  logic [WIN_BITS-1:0]      window_size,
  input  logic [CONF_BITS-1:0]     conf_thresh,
  input  logic [WATCHDOG_SIZE-1:0] watchdog_cnt,
  multi_stream_pf_ctrl_if.master   bus,
  output logic [NUM_STREAMS-1:0]   stream_flush,
  output logic [NUM_STREAMS-1:0]   stream_active,
  output logic                     alloc_fail
);
  localparam int unsigned SW = $clog2(NUM_STREAMS);

  typedef enum logic [1:0] {StIdle, StTrain, StActive, StDrain} st_e;

  st_e                        state_q     [NUM_STREAMS];
  st_e                        state_d     [NUM_STREAMS];
  logic [TID_WIDTH-1:0]       tid_q       [NUM_STREAMS];
  logic [TID_WIDTH-1:0]       tid_d       [NUM_STREAMS];
  logic [BURST_LEN_WIDTH-1:0] len_q       [NUM_STREAMS];
  logic [BURST_LEN_WIDTH-1:0] len_d       [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       prev_addr_q [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       prev_addr_d [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       stride_q    [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       stride_d    [NUM_STREAMS];
  logic [CONF_BITS-1:0]       conf_q      [NUM_STREAMS];
  logic [CONF_BITS-1:0]       conf_d      [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       next_addr_q [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       next_addr_d [NUM_STREAMS];
  logic [WIN_BITS-1:0]        outst_q     [NUM_STREAMS];
  logic [WIN_BITS-1:0]        outst_d     [NUM_STREAMS];
  logic [WATCHDOG_SIZE-1:0]   idle_q      [NUM_STREAMS];
  logic [WATCHDOG_SIZE-1:0]   idle_d      [NUM_STREAMS];

  logic                       pf_valid_q, pf_valid_d;
  logic [ADDR_BITS-1:0]       pf_addr_q, pf_addr_d;
  logic [BURST_LEN_WIDTH-1:0] pf_len_q, pf_len_d;
  logic [TID_WIDTH-1:0]       pf_id_q, pf_id_d;
  logic [SW-1:0]              pf_stream_q, pf_stream_d;
  logic [SW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_STREAMS-1:0]     flush_q, flush_d;
  logic                       alloc_fail_q, alloc_fail_d;

  logic                   ar_hs, ar_in_range, pf_hs, any_idle, alloc_go;
  logic [NUM_STREAMS-1:0] hit, elig;
  logic [SW-1:0]          match_idx, alloc_idx;
  logic [ADDR_BITS-1:0]   delta, train_stride;
  logic [CONF_BITS-1:0]   train_conf;
  logic                   train_go;
  logic                   hi_found, lo_found;
  logic [SW-1:0]          hi_idx, lo_idx;

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a, lo, hi);
    return (a >= lo) && (a <= hi);
  endfunction

  // Access classification: match, allocation target and the TRAIN stride/confidence update.
  always_comb begin
    ar_hs       = bus.s_ar_valid && bus.s_ar_ready;
    ar_in_range = in_range(bus.s_ar_addr, bar, limit);
    pf_hs       = pf_valid_q && bus.pf_ready;
    hit         = '0;
    match_idx   = '0;
    any_idle    = 1'b0;
    alloc_idx   = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (ar_hs && state_q[i] != StIdle && tid_q[i] == bus.s_ar_id) begin
        hit[i]    = 1'b1;
        match_idx = SW'(i);
      end
      if (state_q[i] == StIdle) begin
        any_idle  = 1'b1;
        alloc_idx = SW'(i);
      end
    end
    alloc_go     = ar_hs && ar_in_range && (hit == '0) && any_idle;
    alloc_fail_d = ar_hs && ar_in_range && (hit == '0) && !any_idle;
    delta        = bus.s_ar_addr - prev_addr_q[match_idx];
    if (delta == stride_q[match_idx] && delta != '0) begin
      train_stride = stride_q[match_idx];
      train_conf   = (conf_q[match_idx] == '1) ? conf_q[match_idx] : conf_q[match_idx] + 1'b1;
    end else begin
      train_stride = delta;
      train_conf   = '0;
    end
    train_go = (train_conf >= conf_thresh) && (train_stride != '0);
  end

  always_comb begin
    flush_d = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      state_d[i]     = state_q[i];
      tid_d[i]       = tid_q[i];
      len_d[i]       = len_q[i];
      prev_addr_d[i] = prev_addr_q[i];
      stride_d[i]    = stride_q[i];
      conf_d[i]      = conf_q[i];
      next_addr_d[i] = next_addr_q[i];
      outst_d[i]     = outst_q[i];
      idle_d[i]      = idle_q[i];

      if (alloc_go && alloc_idx == SW'(i)) begin
        state_d[i]     = StTrain;
        tid_d[i]       = bus.s_ar_id;
        len_d[i]       = bus.s_ar_len;
        prev_addr_d[i] = bus.s_ar_addr;
        stride_d[i]    = '0;
        conf_d[i]      = '0;
      end else if (hit[i]) begin
        case (state_q[i])
          StTrain: begin
            prev_addr_d[i] = bus.s_ar_addr;
            stride_d[i]    = train_stride;
            conf_d[i]      = train_conf;
            if (train_go) begin
              state_d[i]     = StActive;
              next_addr_d[i] = bus.s_ar_addr + train_stride;
            end
          end
          StActive: begin
            if (!ar_in_range || bus.s_ar_len != len_q[i]) state_d[i] = StDrain;
            else if (delta == stride_q[i])                 prev_addr_d[i] = bus.s_ar_addr;
            else if (delta != '0)                          state_d[i] = StDrain;
          end
          default: ;
        endcase
      end else if (watchdog_cnt != '0 && idle_q[i] == watchdog_cnt) begin
        if (state_q[i] == StTrain)  state_d[i] = StIdle;
        if (state_q[i] == StActive) state_d[i] = StDrain;
      end

      if (ctrl_flush) begin
        if (state_q[i] == StTrain)  state_d[i] = StIdle;
        if (state_q[i] == StActive) state_d[i] = StDrain;
      end

      // Simultaneous issue and retire on one stream cancel out.
      if (pf_hs && pf_stream_q == SW'(i)) begin
        next_addr_d[i] = next_addr_q[i] + stride_q[i];
        if (!(bus.pf_done && bus.pf_done_stream == SW'(i))) outst_d[i] = outst_q[i] + 1'b1;
      end else if (bus.pf_done && bus.pf_done_stream == SW'(i) && outst_q[i] != '0) begin
        outst_d[i] = outst_q[i] - 1'b1;
      end

      if (state_q[i] == StDrain && outst_d[i] == '0 &&
          !(pf_valid_q && pf_stream_q == SW'(i))) begin
        state_d[i] = StIdle;
        flush_d[i] = 1'b1;
      end

      if (state_d[i] == StIdle || hit[i] || state_d[i] != state_q[i]) idle_d[i] = '0;
      else if (idle_q[i] != '1)                                        idle_d[i] = idle_q[i] + 1'b1;
    end
  end

  // Round-robin: lowest eligible index above the last grant, else lowest eligible overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      elig[i] = state_q[i] == StActive && outst_q[i] < window_size && outst_q[i] != '1 &&
                in_range(next_addr_q[i], bar, limit);
      if (elig[i] && SW'(i) > rr_ptr_q) begin
        hi_found = 1'b1;
        hi_idx   = SW'(i);
      end
      if (elig[i]) begin
        lo_found = 1'b1;
        lo_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_len_d    = pf_len_q;
    pf_id_d     = pf_id_q;
    pf_stream_d = pf_stream_q;
    rr_ptr_d    = rr_ptr_q;
    if (pf_hs) begin
      pf_valid_d = 1'b0;
    end else if (!pf_valid_q && lo_found) begin
      pf_valid_d  = 1'b1;
      pf_stream_d = hi_found ? hi_idx : lo_idx;
      pf_addr_d   = next_addr_q[pf_stream_d];
      pf_len_d    = len_q[pf_stream_d];
      pf_id_d     = tid_q[pf_stream_d];
      rr_ptr_d    = pf_stream_d;
    end
    for (int i = 0; i < NUM_STREAMS; i++) stream_active[i] = state_q[i] == StActive;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        state_q[i]     <= StIdle;
        tid_q[i]       <= '0;
        len_q[i]       <= '0;
        prev_addr_q[i] <= '0;
        stride_q[i]    <= '0;
        conf_q[i]      <= '0;
        next_addr_q[i] <= '0;
        outst_q[i]     <= '0;
        idle_q[i]      <= '0;
      end
      pf_valid_q   <= 1'b0;
      pf_addr_q    <= '0;
      pf_len_q     <= '0;
      pf_id_q      <= '0;
      pf_stream_q  <= '0;
      rr_ptr_q     <= '0;
      flush_q      <= '0;
      alloc_fail_q <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        state_q[i]     <= state_d[i];
        tid_q[i]       <= tid_d[i];
        len_q[i]       <= len_d[i];
        prev_addr_q[i] <= prev_addr_d[i];
        stride_q[i]    <= stride_d[i];
        conf_q[i]      <= conf_d[i];
        next_addr_q[i] <= next_addr_d[i];
        outst_q[i]     <= outst_d[i];
        idle_q[i]      <= idle_d[i];
      end
      pf_valid_q   <= pf_valid_d;
      pf_addr_q    <= pf_addr_d;
      pf_len_q     <= pf_len_d;
      pf_id_q      <= pf_id_d;
      pf_stream_q  <= pf_stream_d;
      rr_ptr_q     <= rr_ptr_d;
      flush_q      <= flush_d;
      alloc_fail_q <= alloc_fail_d;
    end else begin
      // Pulses must not stretch while frozen.
      flush_q      <= '0;
      alloc_fail_q <= 1'b0;
    end
  end

  assign bus.pf_valid  = pf_valid_q;
  assign bus.pf_addr   = pf_addr_q;
  assign bus.pf_len    = pf_len_q;
  assign bus.pf_id     = pf_id_q;
  assign bus.pf_stream = pf_stream_q;
  assign stream_flush  = flush_q;
  assign alloc_fail    = alloc_fail_q;
endmodule

// File: tb/tb_multi_stream_pf_ctrl.sv
// Directed bench for multi_stream_pf_ctrl: training, windowing, arbitration, drain, allocation.
module tb_multi_stream_pf_ctrl;
  logic        clk = 1'b0;
  logic        resetN;
  logic        en;
  logic        ctrl_flush;
  logic [63:0] bar;
  logic [63:0] limit;
  logic [5:0]  window_size;
  logic [1:0]  conf_thresh;
  logic [9:0]  watchdog_cnt;
  logic [3:0]  stream_flush;
  logic [3:0]  stream_active;
  logic        alloc_fail;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] got_addr [8];
  logic [1:0]  got_strm [8];
  int          n_got;

  multi_stream_pf_ctrl_if #(
    .ADDR_BITS(64), .NUM_STREAMS(4), .BURST_LEN_WIDTH(8), .TID_WIDTH(8)
  ) bus ();

  multi_stream_pf_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .en           (en),
    .ctrl_flush   (ctrl_flush),
    .bar          (bar),
    .limit        (limit),
    .window_size  (window_size),
    .conf_thresh  (conf_thresh),
    .watchdog_cnt (watchdog_cnt),
    .bus          (bus),
    .stream_flush (stream_flush),
    .stream_active(stream_active),
    .alloc_fail   (alloc_fail)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0; en = 1'b1; ctrl_flush = 1'b0;
    bar = 64'h0; limit = '1; window_size = 6'd8; conf_thresh = 2'd1; watchdog_cnt = '0;
    bus.s_ar_valid = 1'b0; bus.s_ar_ready = 1'b1; bus.s_ar_addr = '0;
    bus.s_ar_len = '0; bus.s_ar_id = '0;
    bus.pf_ready = 1'b0; bus.pf_done = 1'b0; bus.pf_done_stream = '0;
    step(); step();
    resetN = 1'b1;
    step();
  endtask

  task automatic access(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
    bus.s_ar_valid = 1'b1; bus.s_ar_id = id; bus.s_ar_addr = addr; bus.s_ar_len = len;
    step();
    bus.s_ar_valid = 1'b0;
  endtask

  // Records every prefetch handshake seen over a fixed number of cycles.
  task automatic collect(input int cycles);
    n_got = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.pf_valid && bus.pf_ready) begin
        if (n_got < 8) begin
          got_addr[n_got] = bus.pf_addr;
          got_strm[n_got] = bus.pf_stream;
        end
        n_got++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    resetN = 1'b0;
    step();
    vectors++; if (bus.pf_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_pf_valid: got %b want 0", bus.pf_valid); end
    vectors++; if (stream_active !== 4'b0) begin miscompares++;
      $display("FAIL reset_active: got %b want 0000", stream_active); end
    vectors++; if (stream_flush !== 4'b0) begin miscompares++;
      $display("FAIL reset_flush: got %b want 0000", stream_flush); end
    vectors++; if (alloc_fail !== 1'b0) begin miscompares++;
      $display("FAIL reset_alloc_fail: got %b want 0", alloc_fail); end
    resetN = 1'b1;
    step();
  endtask

  task automatic test_train();
    do_reset();
    access(8'd3, 64'h1000, 8'd4);
    access(8'd3, 64'h1040, 8'd4);
    vectors++; if (stream_active !== 4'b0000) begin miscompares++;
      $display("FAIL train_not_yet_active: got %b want 0000", stream_active); end
    access(8'd3, 64'h1080, 8'd4);
    vectors++; if (stream_active !== 4'b0001) begin miscompares++;
      $display("FAIL train_active: got %b want 0001", stream_active); end
    vectors++; if (bus.pf_valid !== 1'b0) begin miscompares++;
      $display("FAIL train_latency: got pf_valid %b want 0", bus.pf_valid); end
    step();
    vectors++; if (bus.pf_valid !== 1'b1) begin miscompares++;
      $display("FAIL train_first_valid: got %b want 1", bus.pf_valid); end
    vectors++; if (bus.pf_addr !== 64'h10C0) begin miscompares++;
      $display("FAIL train_first_addr: got %h want 10c0", bus.pf_addr); end
    vectors++; if (bus.pf_id !== 8'd3 || bus.pf_len !== 8'd4 || bus.pf_stream !== 2'd0) begin
      miscompares++;
      $display("FAIL train_first_fields: got id %0d len %0d strm %0d want 3 4 0",
               bus.pf_id, bus.pf_len, bus.pf_stream); end
  endtask

  task automatic test_window();
    window_size = 6'd2;
    bus.pf_ready = 1'b1;
    collect(12);
    vectors++; if (n_got !== 2) begin miscompares++;
      $display("FAIL window_count: got %0d want 2", n_got); end
    vectors++; if (got_addr[0] !== 64'h10C0 || got_addr[1] !== 64'h1100) begin miscompares++;
      $display("FAIL window_addrs: got %h %h want 10c0 1100", got_addr[0], got_addr[1]); end
    vectors++; if (bus.pf_valid !== 1'b0) begin miscompares++;
      $display("FAIL window_stall: got pf_valid %b want 0", bus.pf_valid); end
    bus.pf_ready = 1'b0;
    bus.pf_done = 1'b1; bus.pf_done_stream = 2'd0;
    step();
    bus.pf_done = 1'b0;
    for (int k = 0; k < 8 && !bus.pf_valid; k++) step();
    vectors++; if (bus.pf_valid !== 1'b1 || bus.pf_addr !== 64'h1140) begin miscompares++;
      $display("FAIL window_after_done: got valid %b addr %h want 1 1140",
               bus.pf_valid, bus.pf_addr); end
    step(); step(); step();
    vectors++; if (bus.pf_valid !== 1'b1 || bus.pf_addr !== 64'h1140) begin miscompares++;
      $display("FAIL hold_stable: got valid %b addr %h want 1 1140",
               bus.pf_valid, bus.pf_addr); end
    bus.pf_ready = 1'b1;
    resetN = 1'b0;
    #1;
    vectors++; if (bus.pf_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_mid_handshake: got %b want 0", bus.pf_valid); end
    step();
    resetN = 1'b1;
    bus.pf_ready = 1'b0;
    step(); step();
    vectors++; if (bus.pf_valid !== 1'b0 || stream_active !== 4'b0) begin miscompares++;
      $display("FAIL reset_clean: got valid %b active %b want 0 0000",
               bus.pf_valid, stream_active); end
  endtask

  task automatic test_round_robin();
    do_reset();
    access(8'd1, 64'h1000, 8'd4);
    access(8'd2, 64'h8000, 8'd4);
    access(8'd1, 64'h1040, 8'd4);
    access(8'd2, 64'h8100, 8'd4);
    access(8'd1, 64'h1080, 8'd4);
    access(8'd2, 64'h8200, 8'd4);
    vectors++; if (stream_active !== 4'b0011) begin miscompares++;
      $display("FAIL rr_active: got %b want 0011", stream_active); end
    bus.pf_ready = 1'b1;
    collect(8);
    bus.pf_ready = 1'b0;
    vectors++; if (n_got !== 4) begin miscompares++;
      $display("FAIL rr_count: got %0d want 4", n_got); end
    vectors++; if (got_strm[0] !== 2'd0 || got_strm[1] !== 2'd1 ||
                   got_strm[2] !== 2'd0 || got_strm[3] !== 2'd1) begin miscompares++;
      $display("FAIL rr_order: got %0d %0d %0d %0d want 0 1 0 1",
               got_strm[0], got_strm[1], got_strm[2], got_strm[3]); end
    vectors++; if (got_addr[0] !== 64'h10C0 || got_addr[1] !== 64'h8300 ||
                   got_addr[2] !== 64'h1100 || got_addr[3] !== 64'h8400) begin miscompares++;
      $display("FAIL rr_addrs: got %h %h %h %h want 10c0 8300 1100 8400",
               got_addr[0], got_addr[1], got_addr[2], got_addr[3]); end
  endtask

  task automatic test_neg_stride();
    do_reset();
    bar = 64'h1F00;
    access(8'd5, 64'h2000, 8'd2);
    access(8'd5, 64'h1FC0, 8'd2);
    access(8'd5, 64'h1F80, 8'd2);
    bus.pf_ready = 1'b1;
    collect(12);
    bus.pf_ready = 1'b0;
    vectors++; if (n_got !== 2) begin miscompares++;
      $display("FAIL neg_count: got %0d want 2", n_got); end
    vectors++; if (got_addr[0] !== 64'h1F40 || got_addr[1] !== 64'h1F00) begin miscompares++;
      $display("FAIL neg_addrs: got %h %h want 1f40 1f00", got_addr[0], got_addr[1]); end
    vectors++; if (stream_active !== 4'b0001 || bus.pf_valid !== 1'b0) begin miscompares++;
      $display("FAIL neg_stop: got active %b valid %b want 0001 0",
               stream_active, bus.pf_valid); end
  endtask

  task automatic test_flush_drain();
    do_reset();
    window_size = 6'd2;
    access(8'd7, 64'h3000, 8'd1);
    access(8'd7, 64'h3010, 8'd1);
    access(8'd7, 64'h3020, 8'd1);
    bus.pf_ready = 1'b1;
    collect(10);
    bus.pf_ready = 1'b0;
    vectors++; if (n_got !== 2) begin miscompares++;
      $display("FAIL drain_issues: got %0d want 2", n_got); end
    ctrl_flush = 1'b1;
    step();
    ctrl_flush = 1'b0;
    vectors++; if (stream_active !== 4'b0000 || stream_flush !== 4'b0000) begin miscompares++;
      $display("FAIL drain_enter: got active %b flush %b want 0000 0000",
               stream_active, stream_flush); end
    bus.pf_done = 1'b1; bus.pf_done_stream = 2'd0;
    step();
    vectors++; if (stream_flush !== 4'b0000) begin miscompares++;
      $display("FAIL drain_early: got %b want 0000", stream_flush); end
    step();
    bus.pf_done = 1'b0;
    vectors++; if (stream_flush !== 4'b0001) begin miscompares++;
      $display("FAIL drain_pulse: got %b want 0001", stream_flush); end
    step();
    vectors++; if (stream_flush !== 4'b0000) begin miscompares++;
      $display("FAIL drain_pulse_width: got %b want 0000", stream_flush); end
  endtask

  task automatic test_alloc_fail();
    do_reset();
    conf_thresh = 2'd0;
    limit = 64'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      access(8'(10 + i), 64'h4000 + 64'(i) * 64'h1000, 8'd2);
      access(8'(10 + i), 64'h4040 + 64'(i) * 64'h1000, 8'd2);
    end
    vectors++; if (stream_active !== 4'b1111 || alloc_fail !== 1'b0) begin miscompares++;
      $display("FAIL alloc_full: got active %b fail %b want 1111 0", stream_active, alloc_fail); end
    access(8'd20, 64'h9000, 8'd2);
    vectors++; if (alloc_fail !== 1'b1 || stream_active !== 4'b1111) begin miscompares++;
      $display("FAIL alloc_fail_pulse: got fail %b active %b want 1 1111",
               alloc_fail, stream_active); end
    step();
    vectors++; if (alloc_fail !== 1'b0) begin miscompares++;
      $display("FAIL alloc_fail_width: got %b want 0", alloc_fail); end
    access(8'd20, 64'h9000, 8'd2);
    vectors++; if (alloc_fail !== 1'b1) begin miscompares++;
      $display("FAIL alloc_fail_repeat: got %b want 1", alloc_fail); end
    access(8'd21, 64'h1_0000_0000, 8'd2);
    vectors++; if (alloc_fail !== 1'b0 || stream_active !== 4'b1111) begin miscompares++;
      $display("FAIL alloc_out_of_range: got fail %b active %b want 0 1111",
               alloc_fail, stream_active); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_window();
    test_round_robin();
    test_neg_stride();
    test_flush_drain();
    test_alloc_fail();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end
endmodule
